nco_sweep_ctrl: RTL and testbench
=================================

# nco_sweep_ctrl

Frequency-sweep scheduler for the NCO clock generator. It accepts a sweep program of start increment, step, step count and dwell through a valid/ready config port, and drives the NCO's phase-increment input. Increment changes are applied only on an NCO accumulator wrap, so the generated square wave never glitches. It sits between the board control logic and the NCO on the 27 MHz crystal domain.

## Interface
- ACC_W, 32, NCO accumulator and phase-increment width
- DWELL_W, 24, dwell counter width
- DEFAULT_INC, 32'd159_072_862, increment driven after reset (1 MHz at 27 MHz)
- bank1_3v3_xtal_in  in  1  clock, 27 MHz crystal; all logic on its rising edge
- bank3_1v8_sys_rst  in  1  reset, synchronous, active-high
- cfg_valid  in  1  sweep program valid
- cfg_ready  out  1  controller can accept a program
- cfg_start_inc  in  ACC_W  first increment
- cfg_step_inc  in  ACC_W  per-step delta, two's complement
- cfg_num_steps  in  16  number of increments in the sweep; 0 is treated as 1
- cfg_dwell  in  DWELL_W  clock cycles spent per step; 0 is treated as 1
- cfg_loop  in  1  restart the sweep from the start instead of finishing
- abort  in  1  terminate the sweep
- nco_wrap  in  1  one-cycle pulse from the NCO when the accumulator MSB falls (wrap)
- phase_inc  out  ACC_W  increment to the NCO, registered
- inc_update  out  1  one-cycle pulse, high in the first cycle a new phase_inc is visible
- step_idx  out  16  index of the current step
- busy  out  1  high whenever the state is not IDLE
- done  out  1  one-cycle pulse when a non-looping sweep completes

## Operation
- States: IDLE, ARM, DWELL, STEP.
- IDLE
  - cfg_ready=1 when abort=0.
  - When cfg_valid & cfg_ready, capture all cfg_* fields into registers and go to ARM.
  - phase_inc holds its value.
- ARM
  - Wait for nco_wrap.
  - On nco_wrap: phase_inc<=start_inc, step_idx<=0, dwell_cnt<=max(dwell,1), inc_update pulse, go to DWELL.
- DWELL
  - dwell_cnt decrements each cycle.
  - When dwell_cnt reaches 1, go to STEP. Each step therefore spends exactly max(dwell,1) cycles in DWELL.
- STEP, when step_idx == max(num_steps,1)-1:
  - If loop=1, go to ARM; the sweep restarts at the next wrap.
  - Otherwise pulse done and go to IDLE. phase_inc keeps the last step's value.
- STEP, otherwise:
  - Wait for nco_wrap.
  - On nco_wrap: phase_inc<=phase_inc+step_inc modulo 2^ACC_W (no saturation), step_idx+1, reload dwell_cnt, inc_update pulse, go to DWELL.
- Only a nco_wrap sampled while already in ARM or STEP counts. A wrap arriving in the cycle the state is being entered is ignored.
- abort has highest priority in ARM, DWELL and STEP:
  - Next state is IDLE.
  - phase_inc is held; no done pulse and no inc_update.
- abort in IDLE forces cfg_ready=0, so no program is accepted that cycle.
- Keeping increments below 2^(ACC_W-1) is the programmer's responsibility. Wrap-around of the sum is legal and is not flagged.

## Timing
- Reset values: phase_inc=DEFAULT_INC, state=IDLE, step_idx=0, inc_update=0, done=0, busy=0.
- cfg_ready is 0 while reset is asserted and 1 in the first cycle after reset deasserts.
- cfg accepted at edge T: busy=1 and cfg_ready=0 from T+1.
- nco_wrap sampled at edge W in ARM or STEP: the new phase_inc and the inc_update pulse are visible from W+1.
- Dwell of D (D≥1): DWELL is entered at W+1 and occupies D cycles, then STEP for at least 1 cycle. The earliest next update is D+1 cycles after the previous one.
- done and the busy=0 transition happen at the same edge.
- abort at edge A: busy=0 and state=IDLE from A+1. cfg_ready=1 from A+1 if abort has dropped.
- Reset asserted mid-sweep restores all reset values at the next edge. phase_inc returns to DEFAULT_INC.

## Test plan
- Reset, then hold 10 idle cycles -> phase_inc=159_072_862, busy=0, cfg_ready=1, no inc_update.
- Program start=159_072_862, step=159_072_862, steps=3, dwell=4, loop=0; nco_wrap every 10 cycles -> phase_inc takes 159_072_862, 318_145_724, 477_218_586, each change aligned to a wrap with a one-cycle inc_update; step_idx goes 0,1,2; one done pulse; busy falls with done.
- Same program with loop=1, run 3 passes -> sequence repeats, step_idx returns to 0 only after a wrap, no done pulse. Assert abort mid-DWELL -> IDLE next cycle, phase_inc held, no done.
- Start=32'hFFFF_FFF0, step=32'h20, steps=2 -> second increment is 32'h0000_0010 (modulo wrap). Then step=32'hFFFF_FFF0 (-16) from start=100 -> 84.
- steps=0, dwell=0 -> exactly one increment applied, DWELL lasts 1 cycle, done follows. A nco_wrap pulsed in the same cycle cfg is accepted is ignored; the update waits for the next wrap.
- Assert reset mid-STEP and hold cfg_valid high with abort=1 in IDLE -> reset values restored; no program accepted while abort=1.

Source files
------------

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep scheduler for the NCO: steps the phase increment through a
// programmed ramp, applying each change only on an accumulator wrap.
module nco_sweep_ctrl #(
    parameter int               ACC_W       = 32,
    parameter int               DWELL_W     = 24,
    parameter logic [ACC_W-1:0] DEFAULT_INC = ACC_W'(159_072_862)
) (
    input  logic               bank1_3v3_xtal_in,
    input  logic               bank3_1v8_sys_rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [ACC_W-1:0]   cfg_start_inc,
    input  logic [ACC_W-1:0]   cfg_step_inc,
    input  logic [15:0]        cfg_num_steps,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_loop,
    input  logic               abort,
    input  logic               nco_wrap,
    output logic [ACC_W-1:0]   phase_inc,
    output logic               inc_update,
    output logic [15:0]        step_idx,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, ARM, DWELL, STEP} state_t;

    state_t             state;
    logic [ACC_W-1:0]   start_inc;
    logic [ACC_W-1:0]   step_inc;
    logic [15:0]        last_idx;
    logic [DWELL_W-1:0] dwell_len;
    logic [DWELL_W-1:0] dwell_cnt;
    logic               loop_en;

    assign cfg_ready = (state == IDLE) && !abort && !bank3_1v8_sys_rst;
    assign busy      = (state != IDLE);

    always_ff @(posedge bank1_3v3_xtal_in) begin
        if (bank3_1v8_sys_rst) begin
            state      <= IDLE;
            phase_inc  <= DEFAULT_INC;
            step_idx   <= '0;
            inc_update <= 1'b0;
            done       <= 1'b0;
            start_inc  <= '0;
            step_inc   <= '0;
            last_idx   <= '0;
            dwell_len  <= DWELL_W'(1);
            dwell_cnt  <= '0;
            loop_en    <= 1'b0;
        end else begin
            inc_update <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid && cfg_ready) begin
                        // Zero step count / dwell are folded to 1 here so the
                        // sweep states never need to special-case them.
                        start_inc <= cfg_start_inc;
                        step_inc  <= cfg_step_inc;
                        last_idx  <= (cfg_num_steps == 16'd0) ? 16'd0 : cfg_num_steps - 16'd1;
                        dwell_len <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
                        loop_en   <= cfg_loop;
                        state     <= ARM;
                    end
                end
                ARM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (nco_wrap) begin
                        phase_inc  <= start_inc;
                        step_idx   <= '0;
                        dwell_cnt  <= dwell_len;
                        inc_update <= 1'b1;
                        state      <= DWELL;
                    end
                end
                DWELL: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (dwell_cnt <= DWELL_W'(1)) begin
                        state <= STEP;
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
                STEP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (step_idx == last_idx) begin
                        if (loop_en) begin
                            state <= ARM;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (nco_wrap) begin
                        // Modulo add: overflow is the programmer's concern.
                        phase_inc  <= phase_inc + step_inc;
                        step_idx   <= step_idx + 16'd1;
                        dwell_cnt  <= dwell_len;
                        inc_update <= 1'b1;
                        state      <= DWELL;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Self-checking bench for nco_sweep_ctrl: directed programs plus random sweeps
// scored against a wrap-eligibility / arithmetic-ramp reference model.
module tb_nco_sweep_ctrl;
    localparam logic [31:0] DEF = 32'd159_072_862;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_start_inc = '0;
    logic [31:0] cfg_step_inc = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [23:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic        abort = 1'b0;
    logic        nco_wrap = 1'b0;
    logic [31:0] phase_inc;
    logic        inc_update;
    logic [15:0] step_idx;
    logic        busy;
    logic        done;

    int          tests = 0;
    int          fails = 0;
    int          e = 0;
    logic [31:0] model_pi = DEF;
    logic [15:0] model_idx = '0;

    nco_sweep_ctrl dut (
        .bank1_3v3_xtal_in(clk), .bank3_1v8_sys_rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_start_inc(cfg_start_inc), .cfg_step_inc(cfg_step_inc),
        .cfg_num_steps(cfg_num_steps), .cfg_dwell(cfg_dwell), .cfg_loop(cfg_loop),
        .abort(abort), .nco_wrap(nco_wrap), .phase_inc(phase_inc),
        .inc_update(inc_update), .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
        end
    endtask

    // Model: the k-th increment of a pass is start + k*step (mod 2^32). A wrap
    // is honoured iff it lands at least `need` edges after the previous
    // honoured one: 1 after acceptance, D+1 within a pass, D+2 across a loop.
    task automatic run_prog(input logic [31:0] st, input logic [31:0] sp,
                            input int ns, input int dw, input bit lp,
                            input int passes, input int mode, input bit accept_wrap);
        int n, d, ki, total, last, need, cyc;
        bit w, exp_upd, exp_done, finished;
        logic [31:0] kk;
        n = (ns == 0) ? 1 : ns;
        d = (dw == 0) ? 1 : dw;
        check("ready_before_cfg", cfg_ready, 1);
        cfg_start_inc = st; cfg_step_inc = sp; cfg_num_steps = 16'(ns);
        cfg_dwell = 24'(dw); cfg_loop = lp; cfg_valid = 1'b1; nco_wrap = accept_wrap;
        tick();
        cfg_valid = 1'b0; nco_wrap = 1'b0;
        check("busy_after_accept", busy, 1);
        check("ready_after_accept", cfg_ready, 0);
        check("no_upd_at_accept", inc_update, 0);
        check("pi_held_at_accept", phase_inc, model_pi);
        last = e; total = 0; ki = 0; finished = 0; cyc = 0;
        while (!finished && cyc < 4000 && !(lp && total == n * passes)) begin
            w = (mode == 0) ? (cyc % 10 == 9) : ($urandom_range(0, 2) == 0);
            nco_wrap = w;
            tick();
            nco_wrap = 1'b0;
            cyc++;
            need = (total == 0) ? 1 : ((ki == 0) ? d + 2 : d + 1);
            exp_upd = w && (e - last >= need);
            exp_done = !lp && (total == n) && (e - last == d + 1);
            check("inc_update", inc_update, exp_upd);
            if (exp_upd) begin
                kk = 32'(ki);
                model_pi = st + sp * kk;
                model_idx = 16'(ki);
                last = e;
                total++;
                ki = (ki + 1 == n) ? 0 : ki + 1;
            end
            check("phase_inc", phase_inc, model_pi);
            check("step_idx", step_idx, model_idx);
            check("done", done, exp_done);
            if (exp_done) finished = 1;
            check("busy", busy, !finished);
        end
        if (lp) check("loop_passes_complete", total, n * passes);
        else    check("sweep_completed", finished, 1);
    endtask

    initial begin
        // Reset and idle
        tick();
        check("ready_in_reset", cfg_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("ready_after_rst_release", cfg_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_pi", phase_inc, DEF);
            check("idle_busy", busy, 0);
            check("idle_ready", cfg_ready, 1);
            check("idle_upd", inc_update, 0);
        end

        // Linear 1/2/3 MHz sweep, non-looping
        run_prog(DEF, DEF, 3, 4, 1'b0, 1, 0, 1'b0);
        check("final_pi_3mhz", phase_inc, 32'd477_218_586);
        repeat (3) tick();
        check("idle_after_done", busy, 0);

        // Same sweep looping for three passes, then abort mid-DWELL
        run_prog(DEF, DEF, 3, 4, 1'b1, 3, 0, 1'b0);
        check("busy_before_abort", busy, 1);
        abort = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_pi_held", phase_inc, model_pi);
        check("abort_no_done", done, 0);
        check("abort_no_upd", inc_update, 0);
        check("abort_ready_blocked", cfg_ready, 0);
        abort = 1'b0;
        #1;
        check("ready_after_abort", cfg_ready, 1);
        tick();
        check("abort_no_late_done", done, 0);

        // Modulo wrap of the sum, positive and negative steps
        run_prog(32'hFFFF_FFF0, 32'h20, 2, 3, 1'b0, 1, 1, 1'b0);
        check("mod_wrap_pi", phase_inc, 32'h0000_0010);
        run_prog(32'd100, 32'hFFFF_FFF0, 2, 2, 1'b0, 1, 1, 1'b0);
        check("neg_step_pi", phase_inc, 32'd84);

        // Zero steps/dwell, with a wrap coinciding with acceptance
        run_prog(32'h1234_5678, 32'h1, 0, 0, 1'b0, 1, 0, 1'b1);
        check("zero_steps_pi", phase_inc, 32'h1234_5678);

        // Randomised programs
        for (int r = 0; r < 12; r++) begin
            run_prog($urandom, $urandom, $urandom_range(0, 5), $urandom_range(0, 6),
                     1'($urandom_range(0, 1)), 2, 1, 1'($urandom_range(0, 1)));
            if (busy) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                check("rand_abort_busy", busy, 0);
                check("rand_abort_pi", phase_inc, model_pi);
            end
            tick();
        end

        // Reset mid-STEP, then abort blocks a pending program
        run_prog(32'd1000, 32'd10, 3, 2, 1'b0, 1, 0, 1'b0);
        cfg_start_inc = 32'd5000; cfg_step_inc = 32'd7; cfg_num_steps = 16'd3;
        cfg_dwell = 24'd2; cfg_loop = 1'b0; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        nco_wrap = 1'b1;
        tick();
        nco_wrap = 1'b0;
        check("pre_rst_upd", inc_update, 1);
        check("pre_rst_pi", phase_inc, 32'd5000);
        repeat (4) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1; cfg_valid = 1'b1; abort = 1'b1;
        tick();
        check("rst_pi", phase_inc, DEF);
        check("rst_busy", busy, 0);
        check("rst_idx", step_idx, 0);
        check("rst_upd", inc_update, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_hold_ready", cfg_ready, 0);
            check("abort_hold_busy", busy, 0);
            check("abort_hold_pi", phase_inc, DEF);
        end
        cfg_valid = 1'b0; abort = 1'b0;
        tick();
        check("final_ready", cfg_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
